// File: rtl/fibo_pkg.sv
// Shared definitions for the Fibonacci generator/checker family.
// Holds the checker state encoding and the series seed terms.
package fibo_pkg;

    typedef enum logic [1:0] {
        S_WAIT0 = 2'd0,
        S_WAIT1 = 2'd1,
        S_TRACK = 2'd2
    } fibo_state_t;

    localparam int unsigned FIBO_SEED0 = 0;
    localparam int unsigned FIBO_SEED1 = 1;

endpackage

// File: rtl/fibo_chk_sat_cnt.sv
// Saturating up-counter with synchronous reset and count enable.
// It stops at all-ones and never wraps.
module fibo_chk_sat_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fibo_checker.sv
// Streaming Fibonacci checker: locks onto the 0,1 seed and verifies each later term.
// Optional match/error counters are built only when FIBO_CHK_COUNT_EN is defined.
module fibo_checker
    import fibo_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fibo_valid,
    input  logic [WIDTH-1:0] fibo_in,
    output logic             locked,
    output logic             mismatch,
    output logic [WIDTH-1:0] expected,
    output logic [CNT_W-1:0] match_count,
    output logic [CNT_W-1:0] err_count
);

    fibo_state_t      r_state;
    logic [WIDTH-1:0] r_prev1;
    logic [WIDTH-1:0] r_prev2;
    logic             r_locked;
    logic             r_mismatch;
    logic [WIDTH-1:0] r_expected;

    logic [WIDTH-1:0] w_sum;
    logic             w_track_valid;
    logic             w_hit;

    // Carry is dropped on purpose: the generator wraps modulo 2^WIDTH.
    assign w_sum         = r_prev1 + r_prev2;
    assign w_track_valid = fibo_valid && (r_state == S_TRACK);
    assign w_hit         = w_track_valid && (fibo_in == w_sum);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_WAIT0;
            r_prev1    <= '0;
            r_prev2    <= '0;
            r_locked   <= 1'b0;
            r_mismatch <= 1'b0;
            r_expected <= '0;
        end else begin
            r_mismatch <= 1'b0;
            if (fibo_valid) begin
                case (r_state)
                    S_WAIT0: begin
                        if (fibo_in == WIDTH'(FIBO_SEED0)) begin
                            r_state <= S_WAIT1;
                        end
                    end
                    S_WAIT1: begin
                        if (fibo_in == WIDTH'(FIBO_SEED1)) begin
                            r_state    <= S_TRACK;
                            r_prev2    <= WIDTH'(FIBO_SEED0);
                            r_prev1    <= WIDTH'(FIBO_SEED1);
                            r_locked   <= 1'b1;
                            r_expected <= WIDTH'(FIBO_SEED0 + FIBO_SEED1);
                        end else if (fibo_in != WIDTH'(FIBO_SEED0)) begin
                            r_state <= S_WAIT0;
                        end
                    end
                    S_TRACK: begin
                        if (w_hit) begin
                            r_prev2    <= r_prev1;
                            r_prev1    <= fibo_in;
                            r_expected <= fibo_in + r_prev1;
                        end else begin
                            // A fresh 0 means the generator restarted: resync at once.
                            r_state    <= (fibo_in == WIDTH'(FIBO_SEED0)) ? S_WAIT1 : S_WAIT0;
                            r_prev1    <= '0;
                            r_prev2    <= '0;
                            r_locked   <= 1'b0;
                            r_mismatch <= 1'b1;
                            r_expected <= '0;
                        end
                    end
                    default: begin
                        r_state <= S_WAIT0;
                    end
                endcase
            end
        end
    end

    assign locked   = r_locked;
    assign mismatch = r_mismatch;
    assign expected = r_expected;

`ifdef FIBO_CHK_COUNT_EN
    logic w_miss;
    assign w_miss = w_track_valid && !w_hit;

    fibo_chk_sat_cnt #(.CNT_W(CNT_W)) u_match_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_hit),
        .o_count (match_count)
    );

    fibo_chk_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_miss),
        .o_count (err_count)
    );
`else
    assign match_count = '0;
    assign err_count   = '0;
`endif

endmodule

// File: tb/tb_fibo_checker.sv
// Self-checking bench for fibo_checker: directed scenarios plus randomized streams
// compared every cycle against a term-list reference model.
module tb_fibo_checker;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 4;
    localparam int MODV = 1 << WIDTH;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             fibo_valid;
    logic [WIDTH-1:0] fibo_in;
    logic             locked;
    logic             mismatch;
    logic [WIDTH-1:0] expected;
    logic [CNT_W-1:0] match_count;
    logic [CNT_W-1:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: list of accepted terms plus "locked" and "seen a seed zero".
    int terms[$];
    bit m_locked;
    bit m_seen0;
    bit m_mism;
    int m_match;
    int m_err;

    fibo_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .fibo_valid  (fibo_valid),
        .fibo_in     (fibo_in),
        .locked      (locked),
        .mismatch    (mismatch),
        .expected    (expected),
        .match_count (match_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_expected();
        if (!m_locked) return 0;
        return (terms[terms.size()-1] + terms[terms.size()-2]) % MODV;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_update(input bit v, input int d, input bit r);
        m_mism = 1'b0;
        if (r) begin
            m_locked = 1'b0;
            m_seen0  = 1'b0;
            terms.delete();
            m_match  = 0;
            m_err    = 0;
        end else if (v) begin
            if (m_locked) begin
                if (d == model_expected()) begin
                    terms.push_back(d);
                    if (terms.size() > 2) void'(terms.pop_front());
`ifdef FIBO_CHK_COUNT_EN
                    m_match = sat_inc(m_match);
`endif
                end else begin
                    m_mism   = 1'b1;
                    m_locked = 1'b0;
                    m_seen0  = (d == 0);
                    terms.delete();
`ifdef FIBO_CHK_COUNT_EN
                    m_err = sat_inc(m_err);
`endif
                end
            end else if (m_seen0) begin
                if (d == 1) begin
                    m_locked = 1'b1;
                    terms.delete();
                    terms.push_back(0);
                    terms.push_back(1);
                end else if (d != 0) begin
                    m_seen0 = 1'b0;
                end
            end else if (d == 0) begin
                m_seen0 = 1'b1;
            end
        end
    endtask

    task automatic step(input bit v, input int d, input bit r);
        fibo_valid = v;
        fibo_in    = WIDTH'(d);
        reset      = r;
        @(posedge clk);
        model_update(v, d, r);
        #1;
        check("locked",      32'(locked),      32'(m_locked));
        check("mismatch",    32'(mismatch),    32'(m_mism));
        check("expected",    32'(expected),    32'(model_expected()));
        check("match_count", 32'(match_count), 32'(m_match));
        check("err_count",   32'(err_count),   32'(m_err));
    endtask

    task automatic stream(input int s[$], input bit gaps);
        foreach (s[i]) begin
            step(1'b1, s[i], 1'b0);
            if (gaps) step(1'b0, int'($urandom_range(0, MODV-1)), 1'b0);
        end
    endtask

    initial begin
        int s_wrap[$] = '{0, 1, 1, 2, 3, 5, 8, 13, 5, 2, 7, 9, 0, 9};
        int s_bad[$]  = '{0, 1, 1, 2, 4, 6, 0, 1, 1, 2};
        int s_rsync[$] = '{0, 1, 1, 2, 3, 0, 1, 1, 2};
        int s_short[$] = '{0, 1, 1, 2};
        int s_miss[$] = '{0, 1, 7};
        int d;

        reset      = 1'b1;
        fibo_valid = 1'b0;
        fibo_in    = '0;
        step(1'b0, 0, 1'b1);
        step(1'b1, 0, 1'b1);

        stream(s_wrap, 1'b0);
        step(1'b1, 0, 1'b1);
        stream(s_bad, 1'b0);
        step(1'b1, 0, 1'b1);
        stream(s_rsync, 1'b0);
        step(1'b1, 0, 1'b1);
        stream(s_short, 1'b1);
        stream(s_short, 1'b0);
        // Reset during track with a correct term present: that term is discarded.
        step(1'b1, 3, 1'b1);
        step(1'b1, 0, 1'b0);
        for (int k = 0; k < 20; k++) stream(s_miss, 1'b0);

        for (int k = 0; k < 3000; k++) begin
            if (m_locked && ($urandom_range(0, 7) != 0)) d = model_expected();
            else if ($urandom_range(0, 2) == 0) d = int'($urandom_range(0, 1));
            else d = int'($urandom_range(0, MODV-1));
            step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 499) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fibo_checker.md
# fibo_checker

Streaming Fibonacci sequence checker. It is the consumer side of the Fibonacci generator family: it samples a WIDTH-bit series on a valid strobe and locks onto the 0, 1 seed. It then verifies that every further sample equals the sum of the previous two, modulo 2^WIDTH, because the generator discards its carry. It sits downstream of a generator in lab top-levels and drives pass/fail and status for self-checking benches and board LEDs.

## Interface
- WIDTH, 4, data width of the series under test
- CNT_W, 8, width of the match and error counters
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- fibo_valid  input  1  fibo_in is a new series term this cycle
- fibo_in  input  WIDTH  series term under test
- locked  output  1  checker is tracking a verified sequence
- mismatch  output  1  one-cycle pulse: accepted term was wrong
- expected  output  WIDTH  next term the checker expects
- match_count  output  CNT_W  saturating count of correct terms while locked
- err_count  output  CNT_W  saturating count of mismatches

## Operation
- History registers prev1 and prev2 hold the last two accepted terms. Next expected term = prev1 + prev2, truncated to WIDTH bits.
- FSM states:
  - S_WAIT0: wait for a term equal to 0.
  - S_WAIT1: 0 seen; wait for 1.
  - S_TRACK: locked.
- Transitions, evaluated only when fibo_valid=1:
  - S_WAIT0: fibo_in=0 → S_WAIT1. Any other value → stay. No mismatch, no count.
  - S_WAIT1: fibo_in=1 → S_TRACK, prev2=0, prev1=1. fibo_in=0 → stay. Any other value → S_WAIT0. No mismatch pulse in either seed state.
  - S_TRACK, fibo_in = expected: shift history (prev2←prev1, prev1←fibo_in), match_count+1.
  - S_TRACK, fibo_in ≠ expected: mismatch pulse, err_count+1, history cleared. If fibo_in=0, go to S_WAIT1 (immediate resync on a restarted generator). Otherwise go to S_WAIT0.
- fibo_valid=0: state, history and counters hold; mismatch=0.
- Counters saturate at 2^CNT_W−1 and never wrap.
- expected is valid only in S_TRACK. Outside S_TRACK it is driven to 0.

## Timing
- All outputs are registered. Response appears on the cycle after the fibo_valid sample.
- locked rises the cycle after the seed term 1 is accepted. It falls the cycle after a mismatching term.
- mismatch is high for exactly one cycle per wrong term. Back-to-back wrong terms give back-to-back pulses only while in S_TRACK.
- fibo_valid may be asserted every cycle; there is no backpressure.
- Reset values: state S_WAIT0, prev1=prev2=0, locked=0, mismatch=0, expected=0, match_count=0, err_count=0.
- Reset asserted mid-sequence overrides any concurrent fibo_valid. The first post-reset sample is taken the cycle after reset deasserts.

## Configuration
- FIBO_CHK_COUNT_EN:
  - Defined: match_count and err_count are implemented as described.
  - Undefined: no counter registers; both ports are tied to 0. FSM, locked, mismatch and expected are unchanged.

## Structure
- Shared package fibo_pkg holds:
  - state encodings S_WAIT0/S_WAIT1/S_TRACK (2-bit)
  - seed constants FIBO_SEED0=0, FIBO_SEED1=1
  - these are shared with the generator's reset values.
- One sub-module: fibo_chk_sat_cnt, a CNT_W saturating counter with synchronous reset and enable, instanced twice under FIBO_CHK_COUNT_EN.

## Test plan
- Reset, then stream 0,1,1,2,3,5,8,13,5,2,7,9,0,9 (WIDTH=4, continuous valid) → locked high from the cycle after the 1st term 1. No mismatch. match_count=12. expected shows 5 after 13, showing wrap.
- Lock, then inject 4 where 3 is expected → one mismatch pulse, err_count=1, locked drops. Following 6 is ignored (S_WAIT0). Then 0,1 relocks.
- Lock, then inject 0 where 5 is expected → mismatch pulse, state S_WAIT1. Next 1 relocks with no intermediate S_WAIT0.
- Valid gaps: 0,1,1,2 with fibo_valid toggling 1,0 every cycle → same results as continuous. Outputs hold during gaps.
- Reset asserted with fibo_valid=1 mid-track → all outputs return to reset values the next cycle. Sample during reset is discarded.
- With FIBO_CHK_COUNT_EN and CNT_W=2, force 5 mismatches → err_count saturates at 3. Without the macro → both counts read 0 throughout.
